// File: rtl/mux_pkg.sv
// Shared definitions for the 4:1 lane-select mux: lane count and select encodings.
package mux_pkg;

  localparam int LANES = 4;
  localparam int SEL_W = 2;

  localparam logic [SEL_W-1:0] SEL_L0 = 2'd0;
  localparam logic [SEL_W-1:0] SEL_L1 = 2'd1;
  localparam logic [SEL_W-1:0] SEL_L2 = 2'd2;
  localparam logic [SEL_W-1:0] SEL_L3 = 2'd3;

endpackage

// File: rtl/mux2_to_1.sv
// Bit-sliced 2:1 mux, purely combinational; no flow control.
// The ternary keeps an X on sel visible instead of forcing a default lane.
module mux2_to_1 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux4_to_1.sv
// 4:1 lane select built from a tree of 2:1 muxes; 1-cycle latency (REG_OUT=1) or 0 (REG_OUT=0).
// No flow control: the output tracks the inputs every cycle.
module mux4_to_1
  import mux_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LANES*WIDTH-1:0] i,
  input  logic [SEL_W-1:0]       s,
  output logic [WIDTH-1:0]       out
);

  logic [WIDTH-1:0] lo_y;
  logic [WIDTH-1:0] hi_y;
  logic [WIDTH-1:0] sel_data;

  // s[0] picks within each lane pair, s[1] picks between the pairs.
  mux2_to_1 #(.WIDTH(WIDTH)) u_mux_lo (
    .a   (i[0*WIDTH +: WIDTH]),
    .b   (i[1*WIDTH +: WIDTH]),
    .sel (s[0]),
    .y   (lo_y)
  );

  mux2_to_1 #(.WIDTH(WIDTH)) u_mux_hi (
    .a   (i[2*WIDTH +: WIDTH]),
    .b   (i[3*WIDTH +: WIDTH]),
    .sel (s[0]),
    .y   (hi_y)
  );

  mux2_to_1 #(.WIDTH(WIDTH)) u_mux_fin (
    .a   (lo_y),
    .b   (hi_y),
    .sel (s[1]),
    .y   (sel_data)
  );

  generate
    if (REG_OUT) begin : g_reg
      logic [WIDTH-1:0] out_q;
      logic [WIDTH-1:0] out_d;

      assign out_d = sel_data;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_q <= '0;
        end else begin
          out_q <= out_d;
        end
      end

      assign out = out_q;
    end else begin : g_comb
      // Clock and reset are intentionally ignored in the combinational build.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign out            = sel_data;
    end
  endgenerate

endmodule

// File: tb/tb_mux4_to_1.sv
// Randomized and directed checks of mux4_to_1 in registered (WIDTH=1) and combinational (WIDTH=8) builds.
module tb_mux4_to_1;
  import mux_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [3:0]  i;
  logic [1:0]  s;
  logic [0:0]  out;

  logic        clk_c;
  logic        rst_n_c;
  logic [31:0] i_w;
  logic [1:0]  s_w;
  logic [7:0]  out_w;

  int checks;
  int failures;

  mux4_to_1 #(.WIDTH(1), .REG_OUT(1'b1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i     (i),
    .s     (s),
    .out   (out)
  );

  mux4_to_1 #(.WIDTH(8), .REG_OUT(1'b0)) u_dut_c (
    .clk   (clk_c),
    .rst_n (rst_n_c),
    .i     (i_w),
    .s     (s_w),
    .out   (out_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: lane sel of vec is the w-bit field starting at bit sel*w.
  function automatic logic [31:0] ref_sel(input logic [31:0] vec, input int sel, input int w);
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    return (vec >> (sel * w)) & mask;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    logic [31:0] prev_exp;
    logic [31:0] exp;
    logic [3:0]  iso_i;
    logic [3:0]  iso_exp;
    checks   = 0;
    failures = 0;
    clk_c    = 1'b0;
    rst_n_c  = 1'b0;
    i_w      = '0;
    s_w      = '0;

    // Reset holds out low regardless of inputs and clock edges.
    rst_n = 1'b0;
    i     = 4'b1111;
    s     = SEL_L3;
    #2;
    chk("reset_async", 32'(out), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold_edges", 32'(out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_release_pre_edge", 32'(out), 32'h0);
    @(posedge clk);
    #1;
    chk("reset_first_capture", 32'(out), 32'h1);

    // Exhaustive sweep of all select/data combinations.
    for (int sv = 0; sv < 4; sv++) begin
      s = 2'(sv);
      i = 4'h0;
      @(posedge clk);
      #1;
      for (int iv = 0; iv < 16; iv++) begin
        i   = 4'(iv);
        exp = ref_sel(32'(iv), sv, 1);
        @(posedge clk);
        #1;
        chk($sformatf("sweep_s%0d_i%0d", sv, iv), 32'(out), exp);
      end
    end

    // Lane isolation: only lane 2 carries a one.
    iso_i   = 4'b0100;
    iso_exp = 4'b0100;
    i       = iso_i;
    for (int sv = 0; sv < 4; sv++) begin
      s = 2'(sv);
      @(posedge clk);
      #1;
      chk($sformatf("isolate_s%0d", sv), 32'(out), 32'(iso_exp[sv]));
    end

    // Mid-run reset pulse between clock edges.
    s = SEL_L2;
    i = 4'b0100;
    @(posedge clk);
    #1;
    chk("midrst_before", 32'(out), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_immediate_clear", 32'(out), 32'h0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("midrst_released_hold", 32'(out), 32'h0);
    @(posedge clk);
    #1;
    chk("midrst_recover", 32'(out), 32'h1);

    // Simultaneous select and data change.
    s = SEL_L0;
    i = 4'b0001;
    @(posedge clk);
    #1;
    chk("simul_edge1", 32'(out), 32'h1);
    s = SEL_L3;
    i = 4'b1000;
    #1;
    chk("simul_between", 32'(out), 32'h1);
    @(posedge clk);
    #1;
    chk("simul_edge2", 32'(out), 32'h1);
    prev_exp = 32'h1;

    // Combinational build: no clock, reset held low, output follows inputs.
    i_w = 32'hDDCC_BBAA;
    s_w = SEL_L3;
    #1;
    chk("comb_dd", 32'(out_w), 32'hDD);
    s_w = SEL_L1;
    #1;
    chk("comb_bb", 32'(out_w), 32'hBB);

    // Randomized run, including mid-cycle input changes that must not leak through.
    for (int n = 0; n < 300; n++) begin
      i = 4'($urandom);
      s = 2'($urandom);
      #2;
      chk("rand_hold", 32'(out), prev_exp);
      if ($urandom_range(1, 0) == 1) begin
        i = 4'($urandom);
        s = 2'($urandom);
        #1;
        chk("rand_hold_glitch", 32'(out), prev_exp);
      end
      exp = ref_sel(32'(i), int'(s), 1);

      i_w = $urandom;
      s_w = 2'($urandom);
      #1;
      chk("rand_comb", 32'(out_w), ref_sel(i_w, int'(s_w), 8));

      @(posedge clk);
      #1;
      chk("rand_reg", 32'(out), exp);
      prev_exp = exp;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux4_to_1.md
MUX4_TO_1 -- requirements
Module: mux4_to_1

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 The block SHALL have parameter WIDTH, default 1, giving the bit width of each data lane and of out.
REQ-003 The block SHALL have parameter REG_OUT, default 1: 1 means out is registered, 0 means out is combinational.
REQ-004 Port clk: input, 1 bit, rising-edge clock.
REQ-005 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-006 Port i: input, 4*WIDTH bits, four data lanes; lane n occupies bits [n*WIDTH +: WIDTH].
REQ-007 Port s: input, 2 bits, lane select.
REQ-008 Port out: output, WIDTH bits, selected lane.

Function
REQ-009 The block SHALL compute sel_data = lane s of i: s=0 gives i[0], s=1 gives i[1], s=2 gives i[2], s=3 gives i[3] (WIDTH=1).
REQ-010 With REG_OUT=1, out SHALL update to sel_data on each rising clk edge while rst_n=1, giving exactly 1-cycle latency from i or s to out.
REQ-011 With REG_OUT=1, changes to i or s between clock edges SHALL NOT affect out until the next rising edge.
REQ-012 With REG_OUT=0, out SHALL equal sel_data combinationally, with zero latency, and clk and rst_n SHALL have no effect.
REQ-013 All four s codes are legal, so there is no error or default-lane path; unknown or X bits on s SHALL NOT be masked in RTL.
REQ-014 When i and s change at the same time, the registered out SHALL reflect the new s applied to the new i at the next edge.
REQ-015 The selection SHALL be bit-sliced: bit b of out depends only on bit b of each lane, for every b < WIDTH.

Reset
REQ-016 While rst_n=0, out SHALL be all zeros, asynchronously and independent of clk (REG_OUT=1).
REQ-017 Reset deassertion SHALL be synchronised by the integrator; the block SHALL capture sel_data on the first rising edge after rst_n=1.
REQ-018 Reset asserted mid-operation SHALL clear out immediately, without waiting for a clock edge.

Structure
REQ-019 The shared package mux_pkg SHALL hold the select encodings SEL_L0=2'd0, SEL_L1=2'd1, SEL_L2=2'd2 and SEL_L3=2'd3.
REQ-020 The block SHALL be built as a tree of three instances of one sub-module, mux2_to_1 (parameter WIDTH; ports a, b, sel, y).
REQ-021 In the tree, s[0] SHALL drive the two first-level muxes and s[1] SHALL drive the final mux.
REQ-022 The output register SHALL be a single always block with an asynchronous active-low clear, generated only when REG_OUT=1.

Verification
REQ-023 Reset check: hold rst_n=0, apply i=4'b1111 and s=3 -> out=0; release rst_n -> out=1 after the first rising edge.
REQ-024 Exhaustive sweep: for s = 0..3, after 1 cycle at each setting apply i = 0..15, one value per cycle -> out equals i[s] one cycle later for all 64 combinations.
REQ-025 Lane isolation: apply i=4'b0100 and step s through 0,1,2,3 -> out sequence is 0,0,1,0, each one cycle delayed.
REQ-026 Mid-run reset: while s=2 and i=4'b0100 so that out=1, pulse rst_n low between clock edges -> out drops to 0 immediately; after release, out returns to 1 on the next edge.
REQ-027 Combinational mode: with REG_OUT=0, WIDTH=8, i=32'hDDCCBBAA and s=3 -> out=8'hDD with no clock applied.
REQ-028 Simultaneous change: in one cycle move from s=0, i=4'b0001 to s=3, i=4'b1000 -> out=1 on both edges, with no glitch to a lane that was not selected.
